mc_ctrl: RTL and testbench
==========================

Name: mc_ctrl

Overview:
Main control FSM for the multi-cycle MIPS core. It sequences one shared ALU, register file and unified memory across FETCH/DECODE/EXECUTE/MEM/WB cycles. It issues the 4-bit aluop consumed by the existing aludec, plus all datapath write enables and mux selects. It sits beside aludec, taking op/funct from the instruction register and zero from the ALU.

Parameters:
NONE_ALLOWED_ILLEGAL, 0, 1 = an illegal opcode halts in state HALT until reset; 0 = an illegal opcode is skipped and control returns to FETCH.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (0 = reset)
op  input  6  instr[31:26] from IR, stable after FETCH
funct  input  6  instr[5:0] from IR
zero  input  1  ALU zero flag
pcen  output  1  PC write enable
iord  output  1  memory address select: 0 = PC, 1 = ALUOut
memwrite  output  1  memory write
irwrite  output  1  IR load
regwrite  output  1  register file write
regdst  output  1  write register: 0 = rt, 1 = rd
memtoreg  output  1  writeback data: 0 = ALUOut, 1 = Data
alusrca  output  1  ALU A: 0 = PC, 1 = A
alusrcb  output  2  ALU B: 00 = B, 01 = 4, 10 = signed/zero-extended imm, 11 = imm<<2
immzext  output  1  1 = zero-extend imm (andi/ori/xori)
pcsrc  output  2  00 = ALUResult, 01 = ALUOut, 10 = jump target, 11 = A (jr)
aluop  output  4  to aludec
illegal  output  1  one-cycle pulse in DECODE for an unsupported op/funct
mem_ready  input  1  present only with MC_CTRL_MEMREADY_EN

Behaviour:
- State register: 4-bit. Async reset → FETCH. While reset=0, every enable (pcen, irwrite, memwrite, regwrite) and illegal are forced to 0. All other outputs take their FETCH values.
- Outputs are Moore, decoded from state. Exceptions: pcen also depends on zero, and aluop/immzext in IEXEC depend on op.
- Unlisted outputs in each state are 0.
- aluop encodings: 0000 add, 0001 sub, 0010 R-type (funct), 0011 lui, 0100 or, 0101 and, 0111 xor, 1000 jr.
- Per-state outputs and next state:
  - FETCH: alusrcb=01, aluop=0000, irwrite=1, pcen=1 → DECODE.
  - DECODE: alusrcb=11, aluop=0000 (branch target into ALUOut). Next state:
    - lw(100011)/sw(101011) → MEMADR
    - R-type(000000) with funct=001000 → JREX
    - other R-type → RTYPEEX
    - beq(000100) → BEQEX
    - bne(000101) → BNEEX
    - addi(001000), andi(001100), ori(001101), xori(001110), lui(001111) → IEXEC
    - j(000010) → JEX
    - anything else: illegal=1 → FETCH, or → HALT if NONE_ALLOWED_ILLEGAL=1.
  - MEMADR: alusrca=1, alusrcb=10, aluop=0000 → MEMRD (lw) or MEMWR (sw).
  - MEMRD: iord=1 → MEMWB.
  - MEMWB: memtoreg=1, regwrite=1 → FETCH.
  - MEMWR: iord=1, memwrite=1 → FETCH.
  - RTYPEEX: alusrca=1, alusrcb=00, aluop=0010 → ALUWB.
  - ALUWB: regdst=1, regwrite=1 → FETCH.
  - BEQEX: alusrca=1, aluop=0001, pcsrc=01, pcen=zero → FETCH.
  - BNEEX: alusrca=1, aluop=0001, pcsrc=01, pcen=~zero → FETCH.
  - IEXEC: alusrca=1, alusrcb=10. aluop is addi 0000, andi 0101, ori 0100, xori 0111, lui 0011. immzext=1 for andi/ori/xori → IWB.
  - IWB: regwrite=1 → FETCH.
  - JEX: pcsrc=10, pcen=1 → FETCH.
  - JREX: aluop=1000, pcsrc=11, pcen=1 → FETCH.
  - HALT: all enables 0; self-loop until reset.
- Cycle counts per instruction: lw 5, sw 4, R-type 4, I-ALU 4, beq/bne 3, j/jr 3.
- Unused state encodings → FETCH on the next edge, with all enables 0 while in them.

Optional Feature:
MC_CTRL_MEMREADY_EN: adds the mem_ready input.
- With it, FETCH, MEMRD and MEMWR hold their state and mux selects until mem_ready=1.
- Gated that way: irwrite and pcen in FETCH, and memwrite in MEMWR, assert only in a cycle where mem_ready=1.
- The state advances on that same edge.
- Without the macro, memory is treated as single-cycle, and the behaviour is exactly as listed above.

Decomposition:
- Package mc_pkg holds:
  - statetype enum (FETCH..HALT);
  - opcode constants (OP_RTYPE, OP_LW, ...) and FUNCT_JR;
  - ALUOP_* 4-bit constants shared with aludec.
- One sub-module, mc_outdec: purely combinational (state, op, zero, mem_ready) → control outputs.
- The mc_ctrl top holds the state register and the next-state logic.

Test Plan:
- Reset=0 mid-MEMWR → memwrite drops to 0 immediately (asynchronously, before the next edge); after release, state=FETCH with irwrite=1, pcen=1.
- lw (op 100011) → FETCH, DECODE, MEMADR, MEMRD (iord=1), MEMWB (regwrite=1, memtoreg=1): 5 cycles, then FETCH.
- beq with zero=1 → pcen=1, pcsrc=01 in BEQEX; bne with zero=1 → pcen=0; both return to FETCH after 3 cycles.
- ori (001101) → IEXEC shows aluop=0100, immzext=1, alusrcb=10; IWB regwrite=1, regdst=0.
- R-type funct=001000 → JREX: aluop=1000, pcsrc=11, pcen=1. R-type funct=100000 → RTYPEEX then ALUWB with regdst=1.
- op=111111 → illegal=1 for one DECODE cycle, next state FETCH. With NONE_ALLOWED_ILLEGAL=1, next state HALT, where pcen stays 0 for 10 cycles.

Source files
------------

// File: rtl/mc_pkg.sv
// mc_pkg: shared types and constants for the multi-cycle MIPS main controller.
//   statetype  - 4-bit FSM state encoding (FETCH..HALT, encoding 15 unused)
//   OP_*       - opcode field values (instr[31:26])
//   FUNCT_JR   - funct value that turns an R-type into jr
//   ALUOP_*    - 4-bit aluop codes understood by aludec
//   ctrl_t     - bundle of every control output driven by mc_outdec
//   op_is_legal- opcode support check used by the output decoder
package mc_pkg;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        ALUWB   = 4'd7,
        BEQEX   = 4'd8,
        BNEEX   = 4'd9,
        IEXEC   = 4'd10,
        IWB     = 4'd11,
        JEX     = 4'd12,
        JREX    = 4'd13,
        HALT    = 4'd14
    } statetype;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FUNCT_JR = 6'b001000;

    localparam logic [3:0] ALUOP_ADD   = 4'b0000;
    localparam logic [3:0] ALUOP_SUB   = 4'b0001;
    localparam logic [3:0] ALUOP_RTYPE = 4'b0010;
    localparam logic [3:0] ALUOP_LUI   = 4'b0011;
    localparam logic [3:0] ALUOP_OR    = 4'b0100;
    localparam logic [3:0] ALUOP_AND   = 4'b0101;
    localparam logic [3:0] ALUOP_XOR   = 4'b0111;
    localparam logic [3:0] ALUOP_JR    = 4'b1000;

    typedef struct packed {
        logic       pcen;
        logic       iord;
        logic       memwrite;
        logic       irwrite;
        logic       regwrite;
        logic       regdst;
        logic       memtoreg;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic       immzext;
        logic [1:0] pcsrc;
        logic [3:0] aluop;
        logic       illegal;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE = 18'b0;

    // Every R-type funct is accepted (jr or ALU op), so legality is opcode-only.
    function automatic logic op_is_legal(input logic [5:0] op);
        logic legal;
        case (op)
            OP_RTYPE, OP_J, OP_BEQ, OP_BNE, OP_ADDI, OP_ANDI,
            OP_ORI, OP_XORI, OP_LUI, OP_LW, OP_SW: legal = 1'b1;
            default:                                legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/mc_ctrl_if.sv
// mc_ctrl_if: bundle between the main controller and the datapath.
//   Datapath -> controller: op, funct, zero (and mem_ready when
//   MC_CTRL_MEMREADY_EN is defined).
//   Controller -> datapath: write enables, mux selects, aluop, illegal.
//   master modport = controller side, slave modport = datapath side.
interface mc_ctrl_if;
    import mc_pkg::*;

    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
`ifdef MC_CTRL_MEMREADY_EN
    logic       mem_ready;
`endif
    logic       pcen;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic       regdst;
    logic       memtoreg;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       immzext;
    logic [1:0] pcsrc;
    logic [3:0] aluop;
    logic       illegal;

`ifdef MC_CTRL_MEMREADY_EN
    modport master (
        input  op, funct, zero, mem_ready,
        output pcen, iord, memwrite, irwrite, regwrite, regdst, memtoreg,
               alusrca, alusrcb, immzext, pcsrc, aluop, illegal
    );
    modport slave (
        output op, funct, zero, mem_ready,
        input  pcen, iord, memwrite, irwrite, regwrite, regdst, memtoreg,
               alusrca, alusrcb, immzext, pcsrc, aluop, illegal
    );
`else
    modport master (
        input  op, funct, zero,
        output pcen, iord, memwrite, irwrite, regwrite, regdst, memtoreg,
               alusrca, alusrcb, immzext, pcsrc, aluop, illegal
    );
    modport slave (
        output op, funct, zero,
        input  pcen, iord, memwrite, irwrite, regwrite, regdst, memtoreg,
               alusrca, alusrcb, immzext, pcsrc, aluop, illegal
    );
`endif

endinterface

// File: rtl/mc_outdec.sv
// mc_outdec: combinational control-output decoder for the main FSM.
//   state     - current FSM state
//   op        - opcode from IR (selects aluop/immzext in IEXEC, illegal in DECODE)
//   zero      - ALU zero flag (branch pcen)
//   mem_ready - memory handshake, only with MC_CTRL_MEMREADY_EN
//   ctrl      - all control outputs (Moore, except pcen on zero and IEXEC on op)
module mc_outdec
    import mc_pkg::*;
(
    input  statetype   state,
    input  logic [5:0] op,
    input  logic       zero,
`ifdef MC_CTRL_MEMREADY_EN
    input  logic       mem_ready,
`endif
    output ctrl_t      ctrl
);

    logic mem_go_s;

`ifdef MC_CTRL_MEMREADY_EN
    assign mem_go_s = mem_ready;
`else
    assign mem_go_s = 1'b1;
`endif

    // Per-state decode of control outputs; anything not set stays 0.
    always_comb begin
        ctrl = CTRL_NONE;
        case (state)
            FETCH: begin
                ctrl.alusrcb = 2'b01;
                ctrl.aluop   = ALUOP_ADD;
                ctrl.irwrite = mem_go_s;
                ctrl.pcen    = mem_go_s;
            end
            DECODE: begin
                // ALU precomputes the branch target into ALUOut
                ctrl.alusrcb = 2'b11;
                ctrl.aluop   = ALUOP_ADD;
                ctrl.illegal = ~op_is_legal(op);
            end
            MEMADR: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = 2'b10;
                ctrl.aluop   = ALUOP_ADD;
            end
            MEMRD: begin
                ctrl.iord = 1'b1;
            end
            MEMWB: begin
                ctrl.memtoreg = 1'b1;
                ctrl.regwrite = 1'b1;
            end
            MEMWR: begin
                ctrl.iord     = 1'b1;
                ctrl.memwrite = mem_go_s;
            end
            RTYPEEX: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = 2'b00;
                ctrl.aluop   = ALUOP_RTYPE;
            end
            ALUWB: begin
                ctrl.regdst   = 1'b1;
                ctrl.regwrite = 1'b1;
            end
            BEQEX: begin
                ctrl.alusrca = 1'b1;
                ctrl.aluop   = ALUOP_SUB;
                ctrl.pcsrc   = 2'b01;
                ctrl.pcen    = zero;
            end
            BNEEX: begin
                ctrl.alusrca = 1'b1;
                ctrl.aluop   = ALUOP_SUB;
                ctrl.pcsrc   = 2'b01;
                ctrl.pcen    = ~zero;
            end
            IEXEC: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = 2'b10;
                case (op)
                    OP_ANDI: begin
                        ctrl.aluop   = ALUOP_AND;
                        ctrl.immzext = 1'b1;
                    end
                    OP_ORI: begin
                        ctrl.aluop   = ALUOP_OR;
                        ctrl.immzext = 1'b1;
                    end
                    OP_XORI: begin
                        ctrl.aluop   = ALUOP_XOR;
                        ctrl.immzext = 1'b1;
                    end
                    OP_LUI: begin
                        ctrl.aluop   = ALUOP_LUI;
                    end
                    default: begin
                        ctrl.aluop   = ALUOP_ADD;
                    end
                endcase
            end
            IWB: begin
                ctrl.regwrite = 1'b1;
            end
            JEX: begin
                ctrl.pcsrc = 2'b10;
                ctrl.pcen  = 1'b1;
            end
            JREX: begin
                ctrl.aluop = ALUOP_JR;
                ctrl.pcsrc = 2'b11;
                ctrl.pcen  = 1'b1;
            end
            HALT: begin
                ctrl = CTRL_NONE;
            end
            default: begin
                // unused encodings: everything off until FETCH
                ctrl = CTRL_NONE;
            end
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: main control FSM of the multi-cycle MIPS core.
//   clk   - rising-edge clock
//   reset - asynchronous active-low reset (0 = reset)
//   bus   - mc_ctrl_if.master: op/funct/zero in, control outputs out
// Parameter NONE_ALLOWED_ILLEGAL: 1 = illegal opcode parks in HALT until
// reset, 0 = illegal opcode is skipped back to FETCH.
// Optional macro MC_CTRL_MEMREADY_EN: FETCH/MEMRD/MEMWR wait for
// bus.mem_ready before advancing; without it memory is single-cycle.
module mc_ctrl
    import mc_pkg::*;
#(
    parameter bit NONE_ALLOWED_ILLEGAL = 1'b0
)
(
    input  logic       clk,
    input  logic       reset,
    mc_ctrl_if.master  bus
);

    statetype state_r;
    statetype state_next_s;
    ctrl_t    dec_s;
    logic     mem_go_s;

`ifdef MC_CTRL_MEMREADY_EN
    assign mem_go_s = bus.mem_ready;
`else
    assign mem_go_s = 1'b1;
`endif

    // State register, asynchronously returned to FETCH by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= FETCH;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = FETCH;
        case (state_r)
            FETCH: begin
                state_next_s = mem_go_s ? DECODE : FETCH;
            end
            DECODE: begin
                case (bus.op)
                    OP_LW, OP_SW: state_next_s = MEMADR;
                    OP_RTYPE: begin
                        if (bus.funct == FUNCT_JR) begin
                            state_next_s = JREX;
                        end else begin
                            state_next_s = RTYPEEX;
                        end
                    end
                    OP_BEQ:  state_next_s = BEQEX;
                    OP_BNE:  state_next_s = BNEEX;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI:
                             state_next_s = IEXEC;
                    OP_J:    state_next_s = JEX;
                    default: state_next_s = NONE_ALLOWED_ILLEGAL ? HALT : FETCH;
                endcase
            end
            MEMADR:  state_next_s = (bus.op == OP_LW) ? MEMRD : MEMWR;
            MEMRD:   state_next_s = mem_go_s ? MEMWB : MEMRD;
            MEMWB:   state_next_s = FETCH;
            MEMWR:   state_next_s = mem_go_s ? FETCH : MEMWR;
            RTYPEEX: state_next_s = ALUWB;
            ALUWB:   state_next_s = FETCH;
            BEQEX:   state_next_s = FETCH;
            BNEEX:   state_next_s = FETCH;
            IEXEC:   state_next_s = IWB;
            IWB:     state_next_s = FETCH;
            JEX:     state_next_s = FETCH;
            JREX:    state_next_s = FETCH;
            HALT:    state_next_s = HALT;
            default: state_next_s = FETCH;
        endcase
    end

    mc_outdec u_outdec (
        .state     (state_r),
        .op        (bus.op),
        .zero      (bus.zero),
`ifdef MC_CTRL_MEMREADY_EN
        .mem_ready (bus.mem_ready),
`endif
        .ctrl      (dec_s)
    );

    // Enables are gated by reset directly so they drop the instant reset
    // asserts, without waiting for the state register to settle.
    assign bus.pcen     = dec_s.pcen     & reset;
    assign bus.irwrite  = dec_s.irwrite  & reset;
    assign bus.memwrite = dec_s.memwrite & reset;
    assign bus.regwrite = dec_s.regwrite & reset;
    assign bus.illegal  = dec_s.illegal  & reset;
    assign bus.iord     = dec_s.iord;
    assign bus.regdst   = dec_s.regdst;
    assign bus.memtoreg = dec_s.memtoreg;
    assign bus.alusrca  = dec_s.alusrca;
    assign bus.alusrcb  = dec_s.alusrcb;
    assign bus.immzext  = dec_s.immzext;
    assign bus.pcsrc    = dec_s.pcsrc;
    assign bus.aluop    = dec_s.aluop;

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: directed-vector bench for mc_ctrl. Two instances run side by
// side on the same inputs: dut0 skips illegal opcodes, dut1 halts on them.
// Output vector bit order:
// {pcen,iord,memwrite,irwrite,regwrite,regdst,memtoreg,alusrca,
//  alusrcb[1:0],immzext,pcsrc[1:0],aluop[3:0],illegal}
module tb_mc_ctrl;

    //                             p i m i r r m a  b  z  s  aluop l
    localparam logic [17:0] E_RST   = 18'b0_0_0_0_0_0_0_0_01_0_00_0000_0;
    localparam logic [17:0] E_F     = 18'b1_0_0_1_0_0_0_0_01_0_00_0000_0;
    localparam logic [17:0] E_D     = 18'b0_0_0_0_0_0_0_0_11_0_00_0000_0;
    localparam logic [17:0] E_D_ILL = 18'b0_0_0_0_0_0_0_0_11_0_00_0000_1;
    localparam logic [17:0] E_MADR  = 18'b0_0_0_0_0_0_0_1_10_0_00_0000_0;
    localparam logic [17:0] E_MRD   = 18'b0_1_0_0_0_0_0_0_00_0_00_0000_0;
    localparam logic [17:0] E_MWB   = 18'b0_0_0_0_1_0_1_0_00_0_00_0000_0;
    localparam logic [17:0] E_MWR   = 18'b0_1_1_0_0_0_0_0_00_0_00_0000_0;
    localparam logic [17:0] E_REX   = 18'b0_0_0_0_0_0_0_1_00_0_00_0010_0;
    localparam logic [17:0] E_AWB   = 18'b0_0_0_0_1_1_0_0_00_0_00_0000_0;
    localparam logic [17:0] E_BR_P1 = 18'b1_0_0_0_0_0_0_1_00_0_01_0001_0;
    localparam logic [17:0] E_BR_P0 = 18'b0_0_0_0_0_0_0_1_00_0_01_0001_0;
    localparam logic [17:0] E_I_ORI = 18'b0_0_0_0_0_0_0_1_10_1_00_0100_0;
    localparam logic [17:0] E_I_ADD = 18'b0_0_0_0_0_0_0_1_10_0_00_0000_0;
    localparam logic [17:0] E_I_LUI = 18'b0_0_0_0_0_0_0_1_10_0_00_0011_0;
    localparam logic [17:0] E_IWB   = 18'b0_0_0_0_1_0_0_0_00_0_00_0000_0;
    localparam logic [17:0] E_JEX   = 18'b1_0_0_0_0_0_0_0_00_0_10_0000_0;
    localparam logic [17:0] E_JREX  = 18'b1_0_0_0_0_0_0_0_00_0_11_1000_0;
    localparam logic [17:0] E_HALT  = 18'b0;
    localparam logic [17:0] E_PAD   = 18'b0;

    logic       clk;
    logic       reset;
    logic [5:0] op_v;
    logic [5:0] funct_v;
    logic       zero_v;
    int         n_checks;
    int         n_fail;

    mc_ctrl_if if0 ();
    mc_ctrl_if if1 ();

    assign if0.op    = op_v;
    assign if0.funct = funct_v;
    assign if0.zero  = zero_v;
    assign if1.op    = op_v;
    assign if1.funct = funct_v;
    assign if1.zero  = zero_v;
`ifdef MC_CTRL_MEMREADY_EN
    assign if0.mem_ready = 1'b1;
    assign if1.mem_ready = 1'b1;
`endif

    mc_ctrl #(.NONE_ALLOWED_ILLEGAL(1'b0)) dut0 (.clk(clk), .reset(reset), .bus(if0));
    mc_ctrl #(.NONE_ALLOWED_ILLEGAL(1'b1)) dut1 (.clk(clk), .reset(reset), .bus(if1));

    logic [17:0] v0;
    logic [17:0] v1;
    assign v0 = {if0.pcen, if0.iord, if0.memwrite, if0.irwrite, if0.regwrite,
                 if0.regdst, if0.memtoreg, if0.alusrca, if0.alusrcb,
                 if0.immzext, if0.pcsrc, if0.aluop, if0.illegal};
    assign v1 = {if1.pcen, if1.iord, if1.memwrite, if1.irwrite, if1.regwrite,
                 if1.regdst, if1.memtoreg, if1.alusrca, if1.alusrcb,
                 if1.immzext, if1.pcsrc, if1.aluop, if1.illegal};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [17:0] got, input logic [17:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // Drive one instruction and check both DUTs at each negedge, starting in FETCH.
    task automatic run(input string tag, input logic [5:0] o, input logic [5:0] f,
                       input logic z, input int n, input logic [0:4][17:0] e);
        op_v    = o;
        funct_v = f;
        zero_v  = z;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check_eq($sformatf("%s_c%0d_dut0", tag, i), v0, e[i]);
            check_eq($sformatf("%s_c%0d_dut1", tag, i), v1, e[i]);
        end
    endtask

    initial begin
        logic [0:2][17:0] jpat;
        n_checks = 0;
        n_fail   = 0;
        op_v     = 6'b000000;
        funct_v  = 6'b000000;
        zero_v   = 1'b0;
        reset    = 1'b1;
        #1 reset = 1'b0;
        #1;
        check_eq("reset_dut0", v0, E_RST);
        check_eq("reset_dut1", v1, E_RST);
        @(posedge clk);
        #2 reset = 1'b1;

        run("lw",     6'b100011, 6'b000000, 1'b0, 5, {E_F, E_D, E_MADR, E_MRD, E_MWB});
        run("beq_z1", 6'b000100, 6'b000000, 1'b1, 3, {E_F, E_D, E_BR_P1, E_PAD, E_PAD});
        run("beq_z0", 6'b000100, 6'b000000, 1'b0, 3, {E_F, E_D, E_BR_P0, E_PAD, E_PAD});
        run("bne_z1", 6'b000101, 6'b000000, 1'b1, 3, {E_F, E_D, E_BR_P0, E_PAD, E_PAD});
        run("bne_z0", 6'b000101, 6'b000000, 1'b0, 3, {E_F, E_D, E_BR_P1, E_PAD, E_PAD});
        run("ori",    6'b001101, 6'b000000, 1'b0, 4, {E_F, E_D, E_I_ORI, E_IWB, E_PAD});
        run("addi",   6'b001000, 6'b000000, 1'b0, 4, {E_F, E_D, E_I_ADD, E_IWB, E_PAD});
        run("lui",    6'b001111, 6'b000000, 1'b0, 4, {E_F, E_D, E_I_LUI, E_IWB, E_PAD});
        run("jr",     6'b000000, 6'b001000, 1'b0, 3, {E_F, E_D, E_JREX, E_PAD, E_PAD});
        run("add",    6'b000000, 6'b100000, 1'b0, 4, {E_F, E_D, E_REX, E_AWB, E_PAD});
        run("j",      6'b000010, 6'b000000, 1'b0, 3, {E_F, E_D, E_JEX, E_PAD, E_PAD});

        // reset asserted mid-MEMWR must kill memwrite before the next edge
        run("sw",     6'b101011, 6'b000000, 1'b0, 4, {E_F, E_D, E_MADR, E_MWR, E_PAD});
        #2 reset = 1'b0;
        #1;
        check_eq("sw_rst_memwrite_dut0", {17'b0, if0.memwrite}, 18'b0);
        check_eq("sw_rst_memwrite_dut1", {17'b0, if1.memwrite}, 18'b0);
        check_eq("sw_rst_vec_dut0", v0, E_RST);
        check_eq("sw_rst_vec_dut1", v1, E_RST);
        @(posedge clk);
        #2 reset = 1'b1;
        run("after_rst_j", 6'b000010, 6'b000000, 1'b0, 3, {E_F, E_D, E_JEX, E_PAD, E_PAD});

        // illegal opcode: dut0 returns to FETCH, dut1 parks in HALT
        run("illegal", 6'b111111, 6'b000000, 1'b0, 2, {E_F, E_D_ILL, E_PAD, E_PAD, E_PAD});
        @(posedge clk);
        #1 op_v = 6'b000010;
        jpat = {E_F, E_D, E_JEX};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_eq($sformatf("post_ill_c%0d_dut0", i), v0, jpat[i % 3]);
            check_eq($sformatf("halt_c%0d_dut1", i), v1, E_HALT);
        end
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check_eq("halt_rst_dut1", v1, E_RST);
        @(posedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        check_eq("halt_exit_dut0", v0, E_F);
        check_eq("halt_exit_dut1", v1, E_F);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
